rr_arb_mux: RTL and testbench

//   Parametrised N-channel data multiplexer with built-in arbitration, replacing the

---
 rtl/rr_arb_mux.sv | 112 +++++++++++
 tb/tb_rr_arb_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready multiplexer with round-robin or fixed-priority
// arbitration feeding a single registered output slot.
module rr_arb_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rr_en,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready
);

  // Channel count and last index at the widths used by the scan and pointer logic.
  localparam logic [IDW:0]   NChW   = N_CH[IDW:0];
  localparam logic [IDW-1:0] LastId = IDW'(N_CH - 1);

  // Output slot and round-robin pointer state.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  // Arbitration signals.
  logic [N_CH-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             found;
  logic [IDW-1:0]   start;
  logic [IDW:0]     cand;
  logic             slot_free;
  logic             xfer;

  // Unpacked view of the packed input data bus.
  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The slot can accept a new word when empty or when it drains this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Grant: first valid channel scanning upward from the start index, wrapping at N_CH-1.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    start    = rr_en ? ptr_q : '0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      cand = {1'b0, start} + off[IDW:0];
      if (cand >= NChW) begin
        cand = cand - NChW;
      end
      if (!found && in_valid[cand[IDW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IDW-1:0]]   = 1'b1;
        grant_id               = cand[IDW-1:0];
      end
    end
  end

  // Readiness is withheld during reset so nothing is accepted in the reset cycle.
  always_comb begin
    in_ready = grant & {N_CH{slot_free && rst_n}};
    xfer     = |in_ready;
  end

  // Next-state for the output slot and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // A load wins over a drain, keeping one word per clock throughput.
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_id];
      out_id_d    = grant_id;
      // Pointer advances in both modes so switching to round-robin resumes fairly.
      ptr_d       = (grant_id == LastId) ? '0 : grant_id + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: directed scenarios followed by constrained-random traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_rr_arb_mux;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           rr_en;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int           m_ptr = 0;
  bit           m_ov  = 1'b0;
  logic [W-1:0] m_od  = '0;
  int           m_oid = 0;

  logic [N-1:0] last_er;
  logic [N-1:0] hold;

  always #5 clk = ~clk;

  rr_arb_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rr_en     (rr_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // First valid channel found scanning from the start index modulo N, or -1.
  function automatic int pick(input logic [N-1:0] v, input bit rr, input int p);
    int s;
    s = rr ? p : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(s + k) % N]) return (s + k) % N;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle(output logic [N-1:0] er);
    int           g;
    bit           sf;
    bit           r;
    logic [W-1:0] d;
    #1;
    r  = rst_n;
    sf = !m_ov || out_ready;
    g  = pick(in_valid, rr_en, m_ptr);
    er = '0;
    if (r && sf && g >= 0) er[g] = 1'b1;
    d  = (g >= 0) ? in_data[g*W +: W] : '0;
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (!r) begin
      m_ov = 1'b0; m_od = '0; m_oid = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_ov = 1'b1; m_od = d; m_oid = g; m_ptr = (g + 1) % N;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_id", 32'(out_id), 32'(m_oid));
    @(negedge clk);
  endtask

  initial begin
    // Reset with every channel requesting.
    rst_n     = 1'b0;
    rr_en     = 1'b1;
    out_ready = 1'b1;
    in_valid  = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i * 8'h11);
    cycle(last_er);
    cycle(last_er);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_id", 32'(out_id), 32'd0);

    // Round-robin fairness: ids 0,1,2,3,0 with data ch*0x11.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(last_er);
      check("rr_seq_id", 32'(out_id), 32'(k % N));
      check("rr_seq_data", 32'(out_data), 32'((k % N) * 8'h11));
    end

    // Fixed priority: ch1 always wins over ch3.
    rr_en    = 1'b0;
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fixed_in_ready", 32'(in_ready), 32'b0010);
      cycle(last_er);
      check("fixed_id", 32'(out_id), 32'd1);
    end

    // Backpressure: capture ch2 word, stall three clocks, then expect ch3 next.
    rr_en             = 1'b1;
    in_valid          = 4'b0100;
    in_data[2*W +: W] = 8'hA5;
    cycle(last_er);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle(last_er);
      check("bp_data", 32'(out_data), 32'hA5);
      check("bp_id", 32'(out_id), 32'd2);
    end
    out_ready = 1'b1;
    cycle(last_er);
    check("bp_next_id", 32'(out_id), 32'd3);

    // Sparse wrap: pointer at 3, only ch0 valid, then idles keep the pointer at 1.
    in_valid = 4'b0100;
    cycle(last_er);
    in_valid = 4'b0001;
    cycle(last_er);
    check("wrap_id", 32'(out_id), 32'd0);
    in_valid = 4'b0000;
    for (int k = 0; k < 3; k++) cycle(last_er);
    in_valid = 4'b0011;
    cycle(last_er);
    check("wrap_ptr_id", 32'(out_id), 32'd1);

    // Reset mid-stream while stalled; pointer returns to 0.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    cycle(last_er);
    rst_n = 1'b0;
    cycle(last_er);
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycle(last_er);
    check("midrst_first_id", 32'(out_id), 32'd0);

    // Random traffic; sources hold valid and data until their own transfer.
    hold = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          in_valid[i]       = ($urandom_range(0, 99) < 55);
          in_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 19) == 0) rr_en = ~rr_en;
      rst_n = ($urandom_range(0, 59) != 0);
      cycle(last_er);
      hold = rst_n ? (in_valid & ~last_er) : '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
